rr_arbiter_8: RTL and testbench

- Round-robin arbiter that shares one 8-way resource between eight requesters.
- Keeps the owner index in a register and drives a one-hot grant through the team's 3-to-8 active-high decoder.
- An optional hold timeout pre-empts an owner that has held the grant too long while others wait.
- Sits between requester blocks and any shared bus or port selected by a one-hot select.

---
 rtl/rr_arbiter_8_pkg.sv | 14 +
 rtl/rr_arbiter_8_if.sv | 27 ++
 rtl/rr_arbiter_8_decoder.sv | 19 +
 rtl/rr_arbiter_8.sv | 113 +++++++++++
 tb/tb_rr_arbiter_8.sv | 136 +++++++++++++
 5 files changed

// File: rtl/rr_arbiter_8_pkg.sv
// rr_arbiter_8_pkg
//   Shared definitions for the 8-way round-robin arbiter: FSM state
//   encoding, requester count, and index width.
package rr_arbiter_8_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter_8_if.sv
// rr_arbiter_8_if
//   Requester-side bus of the arbiter.
//   en        : arbiter enable (requester side drives)
//   req       : request vector, bit i = requester i, level-held
//   gnt       : one-hot grant, zero when gnt_valid=0
//   gnt_valid : a grant is active
//   gnt_id    : binary index of the owner, meaningful when gnt_valid=1
//   master = requester side, slave = arbiter side.
interface rr_arbiter_8_if;
  import rr_arbiter_8_pkg::*;

  logic               en;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_valid;
  logic [IDX_W-1:0]   gnt_id;

  modport master (
    output en, req,
    input  gnt, gnt_valid, gnt_id
  );

  modport slave (
    input  en, req,
    output gnt, gnt_valid, gnt_id
  );
endinterface

// File: rtl/rr_arbiter_8_decoder.sv
// decoder_3_to_8_active_high
//   Binary-to-one-hot decoder with active-high enable.
//   x      : 3-bit index
//   enable : when 0 all outputs are 0
//   y      : one-hot output, y[x]=1 when enabled
module decoder_3_to_8_active_high
  import rr_arbiter_8_pkg::*;
(
  input  logic [IDX_W-1:0]   x,
  input  logic               enable,
  output logic [NUM_REQ-1:0] y
);

  always_comb begin
    y = '0;
    if (enable) y[x] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8
//   Round-robin arbiter sharing one resource among eight requesters.
//   The owner index is registered; the one-hot grant is decoded from
//   registers only, so it never glitches on req. An owner that holds the
//   grant MAX_HOLD cycles while others wait is pre-empted (MAX_HOLD=0
//   disables this).
//   clk : system clock
//   rst : synchronous reset, active-high
//   bus : slave side of rr_arbiter_8_if (en, req in; gnt, gnt_valid, gnt_id out)
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst,
  rr_arbiter_8_if.slave  bus
);

  localparam int HOLD_W   = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int HOLD_LIM = (MAX_HOLD < 1) ? 0 : MAX_HOLD - 1;
  localparam bit TO_EN    = (MAX_HOLD != 0);

  arb_state_e         state, state_nx;
  logic [IDX_W-1:0]   gnt_id, gnt_id_nx;
  logic [IDX_W-1:0]   ptr, ptr_nx;
  logic [HOLD_W-1:0]  hold_cnt, hold_nx;
  logic [NUM_REQ-1:0] gnt_w;
  logic [NUM_REQ-1:0] others;
  logic               gnt_valid;

  // First requester after p, scanning p+1 .. p+8 with wrap. Iterating from
  // the farthest candidate down lets the nearest one overwrite the result.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   p);
    logic [IDX_W-1:0] c;
    rr_pick = p;
    for (int k = NUM_REQ; k >= 1; k--) begin
      c = p + IDX_W'(k);
      if (r[c]) rr_pick = c;
    end
  endfunction

  assign gnt_valid = (state == GRANT);

  // Requests other than the current owner's.
  always_comb begin
    others         = bus.req;
    others[gnt_id] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt_id   <= '0;
      ptr      <= IDX_W'(NUM_REQ - 1);
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      gnt_id   <= gnt_id_nx;
      ptr      <= ptr_nx;
      hold_cnt <= hold_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    gnt_id_nx = gnt_id;
    ptr_nx    = ptr;
    hold_nx   = hold_cnt;
    case (state)
      IDLE: begin
        // ptr deliberately untouched on a fresh grant.
        if (bus.en && |bus.req) begin
          gnt_id_nx = rr_pick(bus.req, ptr);
          hold_nx   = '0;
          state_nx  = GRANT;
        end
      end
      GRANT: begin
        if (!bus.en) begin
          state_nx = IDLE;
          hold_nx  = '0;
        end else if (!bus.req[gnt_id]) begin
          // Release: hand over in the same edge when someone is waiting.
          ptr_nx  = gnt_id;
          hold_nx = '0;
          if (|bus.req) gnt_id_nx = rr_pick(bus.req, gnt_id);
          else          state_nx  = IDLE;
        end else if (TO_EN && hold_cnt == HOLD_W'(HOLD_LIM) && |others) begin
          // Pre-empt: owner is excluded, so a competitor always wins.
          ptr_nx    = gnt_id;
          gnt_id_nx = rr_pick(others, gnt_id);
          hold_nx   = '0;
        end else if (hold_cnt != HOLD_W'(HOLD_LIM)) begin
          hold_nx = hold_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  decoder_3_to_8_active_high u_dec (
    .x      (gnt_id),
    .enable (gnt_valid),
    .y      (gnt_w)
  );

  assign bus.gnt       = gnt_w;
  assign bus.gnt_valid = gnt_valid;
  assign bus.gnt_id    = gnt_id;

endmodule

// File: tb/tb_rr_arbiter_8.sv
module tb_rr_arbiter_8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_arbiter_8_if bus ();

  rr_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_own(input string tag, input int id);
    logic [7:0] e;
    e = 8'h01 << id;
    chk({tag, "_vld"}, 32'(bus.gnt_valid), 32'd1);
    chk({tag, "_id"},  32'(bus.gnt_id),    32'(id));
    chk({tag, "_gnt"}, 32'(bus.gnt),       32'(e));
  endtask

  task automatic exp_idle(input string tag);
    chk({tag, "_vld"}, 32'(bus.gnt_valid), 32'd0);
    chk({tag, "_gnt"}, 32'(bus.gnt),       32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.en = 1'b1; bus.req = 8'h00;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    int o;
    rst = 1'b1; bus.en = 1'b1; bus.req = 8'hFF;

    // Reset holds grant off even with all requests up.
    step();
    exp_idle("rst0");
    chk("rst0_id", 32'(bus.gnt_id), 32'd0);
    step();
    exp_idle("rst1");
    rst = 1'b0;
    step();
    exp_own("first", 0);

    // Rotation: each owner drops its request for one cycle.
    o = 0;
    for (int i = 0; i < 8; i++) begin
      bus.req = 8'hFF & ~(8'h01 << o);
      step();
      o = (o + 1) % 8;
      exp_own($sformatf("rot%0d", i), o);
    end

    // Wrap: serve 6 (ptr stays 7), release 6 with 0 and 2 waiting.
    do_reset();
    bus.req = 8'h40;
    step(); exp_own("wrap_6", 6);
    bus.req = 8'h05;
    step(); exp_own("wrap_0", 0);
    bus.req = 8'h04;
    step(); exp_own("wrap_2", 2);
    bus.req = 8'h00;
    step(); exp_idle("wrap_rel");

    // Timeout with MAX_HOLD=4: 3 owns 4 cycles, then 5 takes over.
    do_reset();
    bus.req = 8'h08;
    step(); exp_own("to_c0", 3);
    step(); exp_own("to_c1", 3);
    bus.req = 8'h28;
    step(); exp_own("to_c2", 3);
    step(); exp_own("to_c3", 3);
    step(); exp_own("to_pre", 5);
    bus.req = 8'h08;
    step(); exp_own("to_back", 3);
    // No competitor: owner keeps the grant indefinitely.
    for (int i = 0; i < 110; i++) begin
      step();
      chk("to_hold", 32'(bus.gnt_id), 32'd3);
      chk("to_hold_vld", 32'(bus.gnt_valid), 32'd1);
    end
    // Counter saturated, so a new competitor pre-empts at once.
    bus.req = 8'h28;
    step(); exp_own("to_sat", 5);

    // Enable drop mid-grant, then re-enable.
    do_reset();
    bus.req = 8'h04;
    step(); exp_own("en_2", 2);
    bus.en = 1'b0;
    step(); exp_idle("en_off");
    bus.en = 1'b1; bus.req = 8'h24;
    step(); exp_own("en_back", 2);
    // Move ptr away from 7, then reset mid-grant.
    bus.req = 8'h20;
    step(); exp_own("pre_rst", 5);
    rst = 1'b1;
    step(); exp_idle("rst_mid");
    rst = 1'b0; bus.req = 8'h81;
    step(); exp_own("rst_ptr", 0);

    // Idle: no requests, then requests with enable low.
    bus.req = 8'h00;
    step();
    for (int i = 0; i < 20; i++) begin
      step(); exp_idle("idle_noreq");
    end
    bus.en = 1'b0; bus.req = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      step(); exp_idle("idle_en0");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
